// File: rtl/alu_issue_pkg.sv
// Shared opcode map, ALU control width, FSM state encoding and op helpers
// for the ALU issue controller.
package alu_issue_pkg;

  localparam int unsigned ALU_CTL_W = 13;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_NEG  = 4'd2;
  localparam logic [3:0] OP_NOT  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_DIV  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;
  localparam logic [3:0] OP_SHL  = 4'd11;
  localparam logic [3:0] OP_SHRA = 4'd12;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  // MUL and DIV produce a meaningful high word and use the longer settle time.
  function automatic logic is_wide(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake bundle between the datapath sequencer (master)
// and the ALU issue controller (slave).
interface alu_issue_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_lo;
  logic [31:0] rsp_hi;
  logic        rsp_hi_valid;
  logic        rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_hi_valid, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_hi_valid, rsp_err
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode decode: one-hot ALU control line, wide (MUL/DIV) flag
// and illegal-opcode flag.
module alu_op_decode
  import alu_issue_pkg::*;
(
  input  logic [3:0]           op,
  output logic [ALU_CTL_W-1:0] ctl,
  output logic                 wide,
  output logic                 illegal
);

  always_comb begin
    illegal = (op > OP_SHRA);
    wide    = is_wide(op);
    ctl     = '0;
    if (!illegal) begin
      ctl = ALU_CTL_W'(1) << op;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts op requests, drives operands and one one-hot
// ALU control line for a settle time, returns results. Optional: ALU_DIV0_TRAP_EN.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int unsigned SIMPLE_WAIT = 1,
  parameter int unsigned MULDIV_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  alu_issue_ctrl_if.slave      bus,
  output logic [31:0]          alu_rb,
  output logic [31:0]          alu_ry,
  output logic [ALU_CTL_W-1:0] alu_ctl,
  input  logic [31:0]          alu_lo,
  input  logic [31:0]          alu_hi,
  output logic                 busy
);

  localparam logic [3:0] SIMPLE_CNT = 4'(SIMPLE_WAIT);
  localparam logic [3:0] MULDIV_CNT = 4'(MULDIV_WAIT);

  state_t               state;
  logic [3:0]           cnt;
  logic                 wide_q;
  logic [ALU_CTL_W-1:0] dec_ctl;
  logic                 dec_wide;
  logic                 dec_illegal;
  logic                 reject;

  alu_op_decode u_decode (
    .op      (bus.req_op),
    .ctl     (dec_ctl),
    .wide    (dec_wide),
    .illegal (dec_illegal)
  );

  always_comb begin
`ifdef ALU_DIV0_TRAP_EN
    reject = dec_illegal || ((bus.req_op == OP_DIV) && (bus.req_b == '0));
`else
    reject = dec_illegal;
`endif
  end

  // req_ready/busy/rsp_valid are registered alongside state so every
  // interface output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state            <= IDLE;
      cnt              <= '0;
      wide_q           <= 1'b0;
      alu_rb           <= '0;
      alu_ry           <= '0;
      alu_ctl          <= '0;
      busy             <= 1'b0;
      bus.req_ready    <= 1'b1;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_lo       <= '0;
      bus.rsp_hi       <= '0;
      bus.rsp_hi_valid <= 1'b0;
      bus.rsp_err      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            alu_rb        <= bus.req_a;
            alu_ry        <= bus.req_b;
            wide_q        <= dec_wide;
            busy          <= 1'b1;
            bus.req_ready <= 1'b0;
            if (reject) begin
              state            <= RESP;
              bus.rsp_valid    <= 1'b1;
              bus.rsp_lo       <= '0;
              bus.rsp_hi       <= '0;
              bus.rsp_hi_valid <= 1'b0;
              bus.rsp_err      <= 1'b1;
            end else begin
              state   <= EXEC;
              alu_ctl <= dec_ctl;
              cnt     <= dec_wide ? MULDIV_CNT : SIMPLE_CNT;
            end
          end
        end
        EXEC: begin
          if (cnt == 4'd1) begin
            state            <= RESP;
            cnt              <= '0;
            alu_ctl          <= '0;
            bus.rsp_valid    <= 1'b1;
            bus.rsp_lo       <= alu_lo;
            bus.rsp_hi       <= wide_q ? alu_hi : '0;
            bus.rsp_hi_valid <= wide_q;
            bus.rsp_err      <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            busy          <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU control interface.
- Accepts encoded operation requests over a valid/ready handshake, registers the operands onto Rb/Ry, and drives exactly one one-hot ALU control line for a programmed settle time.
- Captures resultLo/resultHi and returns them over a valid/ready response channel.
- Sits between the datapath sequencer and the ALU; it is the only driver of the ALU control lines.

Parameters:
- SIMPLE_WAIT, 1, EXEC cycles for single-word ops (legal range 1..15).
- MULDIV_WAIT, 4, EXEC cycles for MUL/DIV (legal range 1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge
- clr  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_op  in  4  opcode: 0 AND, 1 OR, 2 NEG, 3 NOT, 4 SUB, 5 ADD, 6 MUL, 7 ROR, 8 ROL, 9 DIV, 10 SHR, 11 SHL, 12 SHRA; 13-15 illegal
- req_a  in  32  operand driven onto Rb
- req_b  in  32  operand driven onto Ry
- alu_rb  out  32  to ALU Rb
- alu_ry  out  32  to ALU Ry
- alu_ctl  out  13  one-hot ALU control; bit i corresponds to opcode i
- alu_lo  in  32  from ALU resultLo
- alu_hi  in  32  from ALU resultHi
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_lo  out  32  captured low result
- rsp_hi  out  32  captured high result (MUL product high word / DIV remainder)
- rsp_hi_valid  out  1  rsp_hi carries meaning (MUL/DIV only)
- rsp_err  out  1  illegal opcode or trapped operation
- busy  out  1  state is not IDLE

Behaviour:
- Reset: clr low at a rising edge forces:
  - state IDLE; all outputs 0 (alu_rb, alu_ry, alu_ctl, rsp_*, busy); wait counter 0.
  - This applies from any state, including mid-EXEC or in RESP with the response not yet taken. The in-flight request is discarded and no response is issued.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_ready=1; alu_ctl=0.
  - On req_valid && req_ready, latch op, req_a to alu_rb, req_b to alu_ry.
  - Legal op: go to EXEC and load the counter with SIMPLE_WAIT, or MULDIV_WAIT for op 6/9.
  - Illegal op (13-15): go directly to RESP with rsp_err=1, rsp_lo=0, rsp_hi=0, rsp_hi_valid=0. alu_ctl never asserts.
- EXEC:
  - alu_ctl = one-hot(op), held constant; alu_rb/alu_ry stable; req_ready=0.
  - Counter decrements each cycle. In the cycle where counter==1, alu_lo (and alu_hi for MUL/DIV) is captured at the clock edge and the next state is RESP.
  - alu_ctl is high for exactly WAIT cycles.
  - For non-MUL/DIV ops: rsp_hi=0 and rsp_hi_valid=0; alu_hi is ignored.
- RESP:
  - rsp_valid=1; alu_ctl=0; req_ready=0.
  - rsp_lo/rsp_hi/rsp_hi_valid/rsp_err are held stable until rsp_valid && rsp_ready.
  - On that handshake, return to IDLE. rsp_valid drops the next cycle; rsp data registers keep their last value.
  - A new request cannot be accepted in the same cycle as the response handshake.
- Latency, with request accepted at edge T:
  - Legal op: EXEC during T+1 .. T+WAIT; rsp_valid asserted from T+WAIT+1.
  - Illegal op: rsp_valid asserted from T+1.
- Invariants:
  - alu_ctl is zero or exactly one-hot at all times.
  - Operands are never changed while alu_ctl is nonzero.
  - alu_rb/alu_ry hold their values outside EXEC (they are not zeroed except by reset).

Optional Feature:
- Macro: ALU_DIV0_TRAP_EN.
- Defined: DIV with req_b==0 is treated as illegal. It goes IDLE to RESP with rsp_err=1, rsp_lo=0, rsp_hi=0, and alu_ctl bit 9 never asserts.
- Undefined: DIV with a zero divisor is issued normally and returns whatever the ALU produces, with rsp_err=0.

Decomposition:
- Package alu_issue_pkg holds:
  - opcode localparams OP_AND..OP_SHRA
  - ALU_CTL_W=13
  - state encoding (IDLE, EXEC, RESP)
  - function is_wide(op), which is true for MUL/DIV
- Sub-module alu_op_decode, combinational: op in; one-hot ctl, wide flag and illegal flag out. Instantiated once.

Test Plan:
- ADD, a=5, b=7, bench ALU model, rsp_ready=1 -> alu_ctl=13'h0020 for exactly 1 cycle at T+1; rsp_valid at T+2 with rsp_lo=12, rsp_hi_valid=0, rsp_err=0.
- MUL, a=32'h0001_0000, b=32'h0001_0000, MULDIV_WAIT=4 -> alu_ctl=13'h0040 for 4 cycles; rsp_valid at T+5 with rsp_lo=0, rsp_hi=1, rsp_hi_valid=1.
- SUB, a=3, b=10, rsp_ready held low 3 cycles after rsp_valid -> rsp outputs stable, req_ready=0 and alu_ctl=0 throughout; IDLE one cycle after rsp_ready rises.
- req_op=14 -> rsp_valid at T+1 with rsp_err=1, rsp_lo=0; alu_ctl stays 0 for the whole transaction.
- DIV, a=20, b=3, with clr driven low in the 2nd EXEC cycle -> at the next edge all outputs are 0, busy=0, no rsp_valid ever; a following AND request completes normally.
- DIV, a=9, b=0 -> with ALU_DIV0_TRAP_EN: rsp_err=1 at T+1, alu_ctl bit 9 never set; without: alu_ctl=13'h0200 for MULDIV_WAIT cycles, rsp_err=0.
